mips_fpga_top: RTL and testbench
================================

// Module: mips_fpga_top
// PURPOSE
//  FPGA board-level counter/timer shell driving LEDs and 7-segment tubes.
//  32-bit counter, preset from DIP switches, controlled by active-low user keys.
//  Count shown on led_light and on two 4-digit hex tube banks, with a status digit.
//  Top of the board image; ports map directly to board pins.
// PARAMETERS
//  TICK_DIV        25_000_000  clocks per count step (>=1; bench uses 4)
//  SCAN_DIV        50_000      clocks per tube-digit advance (>=1; bench uses 2)
//  DEBOUNCE_CYCLES 250_000     stable cycles to accept a key (only with KEY_DEBOUNCE_EN)
// PORTS
//  CLK_IN1            in   1  sole clock, all logic on rising edge
//  reset              in   1  synchronous, active-high reset
//  dip_switch0..3     in   8  preset = {dip3,dip2,dip1,dip0}
//  dip_switch4..6     in   8  unused, ignored
//  dip_switch7        in   8  [1:0] mode; [7:2] ignored
//  user_key           in   8  active-low; [0] load, [1] pause; [7:2] ignored; idle 8'hFF
//  led_light          out  32 ~cnt (LEDs active-low)
//  digital_tube_sel0  out  4  one-hot digit select, bank 0 (cnt[15:0])
//  digital_tube_sel1  out  4  one-hot digit select, bank 1 (cnt[31:16])
//  digital_tube_sel2  out  1  status digit enable, constant 1 out of reset
//  digital_tube0..2   out  8  segments {dp,g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Reset: cnt=0, done=0, prescaler=0, scan index=0; led_light=32'hFFFF_FFFF;
//   sel0=sel1=4'b0001; sel2=1; tube0/1 show hex 0 (8'hC0); tube2 shows mode digit.
//  Keys: user_key passed through 2-FF synchroniser; pressed = sync bit == 0.
//  Load (key0 pressed): cnt<=preset, done<=0, prescaler<=0 next clock; dominates tick/pause.
//  Pause (key1 pressed, no load): cnt and prescaler hold.
//  Tick: prescaler counts 0..TICK_DIV-1; tick is 1-cycle pulse at wrap.
//  Mode 00 one-shot down: cnt-1 per tick; at cnt==0 hold, done=1.
//  Mode 01 auto-reload down: at cnt==0 next tick reloads preset, done pulses 1 cycle.
//  Mode 10 up: cnt+1 per tick, wraps 32'hFFFF_FFFF->0, done stays 0.
//  Mode 11 hold: cnt frozen, prescaler still runs.
//  Mode change mid-count: applies from next tick, cnt unchanged.
//  Preset 0 in mode 00: done=1 on first tick, cnt stays 0.
//  Reset mid-operation: all state to reset values next clock, regardless of keys.
//  Scan: index 0..3 advances every SCAN_DIV clocks; sel = 1<<index;
//   tube0 = hex(cnt[4*idx+:4]), tube1 = hex(cnt[16+4*idx+:4]).
//  tube2 = hex({2'b0,mode}) with dp lit (bit7=0) when done==1.
//  Hex table (active-low): 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
//   8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E.
//  All outputs registered; display lags cnt by <=1 clock.
// CONFIGURATION
//  KEY_DEBOUNCE_EN defined: after sync, each key bit accepted only after
//   DEBOUNCE_CYCLES consecutive equal samples; load/pause use debounced values.
//  Not defined: synchronised key bits used directly (2-cycle latency).
// STRUCTURE
//  Package mips_fpga_pkg: mode encodings (MODE_ONESHOT/RELOAD/UP/HOLD),
//   16-entry 7-seg lookup constant, segment-off constant 8'hFF.
//  Sub-module seg7_hex: 4-bit value -> 8-bit active-low segments; instanced 3x.
//  Counter, prescaler, scan and key logic stay in the top.
// TESTING (TICK_DIV=4, SCAN_DIV=2, macro undefined unless stated)
//  reset high 3 clocks -> led_light=FFFF_FFFF, sel0=0001, tube0=C0, done=0.
//  dip0=7, mode 00, pulse key0 low -> cnt 7 counts to 0 in 7 ticks, done=1, led_light=FFFF_FFFF.
//  mode 01, preset 2 -> sequence 2,1,0,2,1,0; done pulses 1 cycle at each reload.
//  mode 10, preset FFFF_FFFF -> next tick cnt=0, led_light=FFFF_FFFF.
//  key0 and key1 low together during tick -> cnt=preset (load wins); key1 alone freezes cnt.
//  cnt=0000_1234 -> over 8 clocks tube0 cycles 99,B0,A4,F9 with sel0 0001,0010,0100,1000.

Source files
------------

// File: rtl/mips_fpga_pkg.sv
// Shared definitions for the board counter/timer shell.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: mode encodings, active-low 7-segment lookup, blank digit, nibble picker.
package mips_fpga_pkg;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_RELOAD  = 2'b01,
    MODE_UP      = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  // Segment order {dp,g,f,e,d,c,b,a}, a lit segment drives 0.
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Pick nibble idx (0 = least significant) out of a 16-bit half of the count.
  function automatic logic [3:0] nibble_of(input logic [15:0] v, input logic [1:0] idx);
    return v[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/mips_fpga_seg7_hex.sv
// Hex digit to active-low 7-segment pattern, decimal point off.
// Latency: combinational.
// Backpressure: none.
// Ports: val (4-bit digit in), seg (8-bit {dp,g,f,e,d,c,b,a} out).
module seg7_hex
  import mips_fpga_pkg::*;
(
  input  logic [3:0] val,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    seg = SEG_LUT[val];
  end

endmodule

// File: rtl/mips_fpga_top.sv
// Board-level 32-bit counter/timer with DIP preset, key control, LEDs and 7-seg scan.
// Latency: keys act 2 clocks after the pin (plus debounce window if enabled); outputs lag cnt by 1 clock.
// Backpressure: none; free-running display, keys are level-sampled.
// Ports: CLK_IN1/reset (sync, active-high); dip_switch0..3 preset, dip_switch7[1:0] mode;
//   user_key[0] load, [1] pause (active-low); led_light = ~cnt; digital_tube_sel0/1 one-hot
//   digit selects for cnt[15:0]/cnt[31:16]; digital_tube_sel2 status enable; digital_tube0..2 segments.
// Optional: define KEY_DEBOUNCE_EN to debounce the synchronised keys over DEBOUNCE_CYCLES samples.
module mips_fpga_top
  import mips_fpga_pkg::*;
#(
  parameter int TICK_DIV        = 25_000_000,
  parameter int SCAN_DIV        = 50_000,
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic        CLK_IN1,
  input  logic        reset,
  input  logic [7:0]  dip_switch0,
  input  logic [7:0]  dip_switch1,
  input  logic [7:0]  dip_switch2,
  input  logic [7:0]  dip_switch3,
  input  logic [7:0]  dip_switch4,
  input  logic [7:0]  dip_switch5,
  input  logic [7:0]  dip_switch6,
  input  logic [7:0]  dip_switch7,
  input  logic [7:0]  user_key,
  output logic [31:0] led_light,
  output logic [3:0]  digital_tube_sel0,
  output logic [3:0]  digital_tube_sel1,
  output logic        digital_tube_sel2,
  output logic [7:0]  digital_tube0,
  output logic [7:0]  digital_tube1,
  output logic [7:0]  digital_tube2
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  // Board pins that carry no function in this image.
  logic unused_pins;
  assign unused_pins = ^{dip_switch4, dip_switch5, dip_switch6, dip_switch7[7:2], user_key[7:2]};

  logic [31:0]   preset;
  mode_e         mode;
  assign preset = {dip_switch3, dip_switch2, dip_switch1, dip_switch0};
  assign mode   = mode_e'(dip_switch7[1:0]);

  // Key synchroniser; idles high so a reset never looks like a press.
  logic [1:0] key_s1, key_s2, key_eff;

  always_ff @(posedge CLK_IN1) begin
    if (reset) begin
      key_s1 <= 2'b11;
      key_s2 <= 2'b11;
    end else begin
      key_s1 <= user_key[1:0];
      key_s2 <= key_s1;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    key_db;
  logic [DW-1:0] db_cnt [2];

  // A bit flips only after DEBOUNCE_CYCLES samples in a row disagree with the accepted value.
  always_ff @(posedge CLK_IN1) begin
    if (reset) begin
      key_db    <= 2'b11;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (key_s2[i] == key_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          key_db[i] <= key_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign key_eff = key_db;
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES > 0);
  assign key_eff = key_s2;
`endif

  logic load, pause, tick;
  assign load  = ~key_eff[0];
  assign pause = ~key_eff[1];

  logic [31:0]   cnt;
  logic          done;
  logic [TW-1:0] presc;

  // Load outranks pause, so a held pause cannot block a reload of the preset.
  assign tick = !pause && (presc == TICK_LAST);

  always_ff @(posedge CLK_IN1) begin
    if (reset) begin
      cnt   <= '0;
      done  <= 1'b0;
      presc <= '0;
    end else if (load) begin
      cnt   <= preset;
      done  <= 1'b0;
      presc <= '0;
    end else begin
      if (!pause) presc <= tick ? '0 : presc + 1'b1;
      // Reload mode only flags done for the single reload cycle; up mode never flags it.
      if (mode == MODE_RELOAD || mode == MODE_UP) done <= 1'b0;
      if (tick) begin
        case (mode)
          MODE_ONESHOT: begin
            if (cnt == 32'd0) begin
              done <= 1'b1;
            end else begin
              cnt <= cnt - 32'd1;
              if (cnt == 32'd1) done <= 1'b1;
            end
          end
          MODE_RELOAD: begin
            if (cnt == 32'd0) begin
              cnt  <= preset;
              done <= 1'b1;
            end else begin
              cnt <= cnt - 32'd1;
            end
          end
          MODE_UP:  cnt <= cnt + 32'd1;
          default:  ;
        endcase
      end
    end
  end

  // Digit scan.
  logic [SW-1:0] scan_cnt;
  logic [1:0]    scan_idx;

  always_ff @(posedge CLK_IN1) begin
    if (reset) begin
      scan_cnt <= '0;
      scan_idx <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  logic [7:0] seg0, seg1, seg2;

  seg7_hex u_hex0 (.val(nibble_of(cnt[15:0],  scan_idx)), .seg(seg0));
  seg7_hex u_hex1 (.val(nibble_of(cnt[31:16], scan_idx)), .seg(seg1));
  seg7_hex u_hex2 (.val({2'b00, mode}),                   .seg(seg2));

  always_ff @(posedge CLK_IN1) begin
    if (reset) begin
      led_light         <= 32'hFFFF_FFFF;
      digital_tube_sel0 <= 4'b0001;
      digital_tube_sel1 <= 4'b0001;
      digital_tube_sel2 <= 1'b1;
      digital_tube0     <= SEG_LUT[0];
      digital_tube1     <= SEG_LUT[0];
      digital_tube2     <= {1'b1, seg2[6:0]};
    end else begin
      led_light         <= ~cnt;
      digital_tube_sel0 <= 4'b0001 << scan_idx;
      digital_tube_sel1 <= 4'b0001 << scan_idx;
      digital_tube_sel2 <= 1'b1;
      digital_tube0     <= seg0;
      digital_tube1     <= seg1;
      digital_tube2     <= {~done, seg2[6:0]};
    end
  end

endmodule

// File: tb/tb_mips_fpga_top.sv
// Directed bench for mips_fpga_top with TICK_DIV=4, SCAN_DIV=2.
// Latency: n/a.
// Backpressure: n/a.
module tb_mips_fpga_top;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  dip0, dip1, dip2, dip3, dip4, dip5, dip6, dip7;
  logic [7:0]  user_key;
  logic [31:0] led_light;
  logic [3:0]  sel0, sel1;
  logic        sel2;
  logic [7:0]  tube0, tube1, tube2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_fpga_top #(.TICK_DIV(4), .SCAN_DIV(2), .DEBOUNCE_CYCLES(3)) dut (
    .CLK_IN1(clk), .reset(reset),
    .dip_switch0(dip0), .dip_switch1(dip1), .dip_switch2(dip2), .dip_switch3(dip3),
    .dip_switch4(dip4), .dip_switch5(dip5), .dip_switch6(dip6), .dip_switch7(dip7),
    .user_key(user_key), .led_light(led_light),
    .digital_tube_sel0(sel0), .digital_tube_sel1(sel1), .digital_tube_sel2(sel2),
    .digital_tube0(tube0), .digital_tube1(tube1), .digital_tube2(tube2)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] preset;
    int          ticks;
    logic [31:0] exp_cnt;
    bit          chk_done;
    bit          exp_done;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after cnt took the preset.
  task automatic load_preset(input logic [1:0] mode, input logic [31:0] p);
    {dip3, dip2, dip1, dip0} = p;
    dip7 = {6'b0, mode};
    user_key[0] = 1'b0;
    @(negedge clk);
    user_key[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] scan_exp [4];
    logic [3:0] seen;
    int         idx;
    int         dp_count;
    bit         prev_dp, adjacent;
    logic [31:0] seq_exp [7];

    vecs[0]  = '{2'b00, 32'd7,          0, 32'd7,          1'b1, 1'b0};
    vecs[1]  = '{2'b00, 32'd7,          3, 32'd4,          1'b1, 1'b0};
    vecs[2]  = '{2'b00, 32'd7,          7, 32'd0,          1'b0, 1'b0};
    vecs[3]  = '{2'b00, 32'd7,          8, 32'd0,          1'b1, 1'b1};
    vecs[4]  = '{2'b00, 32'd0,          1, 32'd0,          1'b1, 1'b1};
    vecs[5]  = '{2'b10, 32'hFFFF_FFFF,  0, 32'hFFFF_FFFF,  1'b1, 1'b0};
    vecs[6]  = '{2'b10, 32'hFFFF_FFFF,  1, 32'd0,          1'b1, 1'b0};
    vecs[7]  = '{2'b10, 32'd5,          3, 32'd8,          1'b1, 1'b0};
    vecs[8]  = '{2'b11, 32'd9,          3, 32'd9,          1'b1, 1'b0};
    vecs[9]  = '{2'b01, 32'd2,          2, 32'd0,          1'b1, 1'b0};
    vecs[10] = '{2'b01, 32'd3,          5, 32'd2,          1'b1, 1'b0};
    vecs[11] = '{2'b00, 32'h1234_5678,  2, 32'h1234_5676,  1'b1, 1'b0};

    scan_exp[0] = 8'h99; scan_exp[1] = 8'hB0; scan_exp[2] = 8'hA4; scan_exp[3] = 8'hF9;

    reset = 1'b1;
    {dip0, dip1, dip2, dip3, dip4, dip5, dip6} = '0;
    dip7 = 8'h02;
    user_key = 8'hFF;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_led",   led_light, 32'hFFFF_FFFF);
    check("rst_sel0",  {28'd0, sel0}, 32'h1);
    check("rst_sel1",  {28'd0, sel1}, 32'h1);
    check("rst_sel2",  {31'd0, sel2}, 32'h1);
    check("rst_tube0", {24'd0, tube0}, 32'hC0);
    check("rst_tube1", {24'd0, tube1}, 32'hC0);
    check("rst_tube2", {24'd0, tube2}, 32'hA4);
    reset = 1'b0;
    @(negedge clk);

    // Table: load, wait N ticks (4 clocks each, +2 for display lag/margin), compare
    for (int i = 0; i < 12; i++) begin
      load_preset(vecs[i].mode, vecs[i].preset);
      repeat (4 * vecs[i].ticks + 2) @(negedge clk);
      check($sformatf("vec%0d_cnt", i), ~led_light, vecs[i].exp_cnt);
      if (vecs[i].chk_done)
        check($sformatf("vec%0d_done", i), {31'd0, ~tube2[7]}, {31'd0, vecs[i].exp_done});
    end

    // Auto-reload: 2,1,0,2,1,0 with exactly one single-cycle done pulse per reload
    seq_exp[1] = 32'd1; seq_exp[2] = 32'd0; seq_exp[3] = 32'd2;
    seq_exp[4] = 32'd1; seq_exp[5] = 32'd0; seq_exp[6] = 32'd2;
    load_preset(2'b01, 32'd2);
    dp_count = 0; prev_dp = 1'b0; adjacent = 1'b0;
    for (int n = 1; n <= 26; n++) begin
      @(negedge clk);
      if (!tube2[7]) begin
        dp_count++;
        if (prev_dp) adjacent = 1'b1;
      end
      prev_dp = !tube2[7];
      if (n % 4 == 2 && n >= 6)
        check($sformatf("reload_seq%0d", n / 4), ~led_light, seq_exp[n / 4]);
    end
    check("reload_done_pulses", dp_count, 32'd2);
    check("reload_done_width", {31'd0, adjacent}, 32'd0);

    // Pause freezes; load while paused still wins and stays frozen afterwards
    load_preset(2'b10, 32'd5);
    repeat (4) @(negedge clk);
    user_key[1] = 1'b0;
    repeat (20) @(negedge clk);
    check("pause_hold", ~led_light, 32'd6);
    load_preset(2'b10, 32'h40);
    repeat (2) @(negedge clk);
    check("load_over_pause", ~led_light, 32'h40);
    repeat (16) @(negedge clk);
    check("pause_after_load", ~led_light, 32'h40);
    user_key[1] = 1'b1;
    @(negedge clk);

    // Mode change mid-count: up twice, then down twice
    load_preset(2'b10, 32'd10);
    repeat (10) @(negedge clk);
    check("modechg_up", ~led_light, 32'd12);
    dip7 = 8'h00;
    repeat (8) @(negedge clk);
    check("modechg_down", ~led_light, 32'd10);

    // Digit scan on a frozen count
    load_preset(2'b11, 32'h0000_1234);
    repeat (2) @(negedge clk);
    seen = 4'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      idx = -1;
      for (int k = 0; k < 4; k++) if (sel0 == (4'b0001 << k)) idx = k;
      if (idx < 0) begin
        check("scan_sel_onehot", {28'd0, sel0}, 32'h1);
      end else begin
        seen[idx] = 1'b1;
        check($sformatf("scan_tube0_d%0d", idx), {24'd0, tube0}, {24'd0, scan_exp[idx]});
      end
      check("scan_tube1", {24'd0, tube1}, 32'hC0);
      check("scan_sel1", {28'd0, sel1}, {28'd0, sel0});
    end
    check("scan_all_digits", {28'd0, seen}, 32'hF);
    check("scan_tube2_mode3", {24'd0, tube2}, 32'hB0);
    check("scan_sel2", {31'd0, sel2}, 32'h1);

    // Reset mid-operation with both keys held
    user_key = 8'hFC;
    dip7 = 8'h01;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_led",   led_light, 32'hFFFF_FFFF);
    check("midrst_sel0",  {28'd0, sel0}, 32'h1);
    check("midrst_tube0", {24'd0, tube0}, 32'hC0);
    check("midrst_tube2", {24'd0, tube2}, 32'hF9);
    reset = 1'b0;
    user_key = 8'hFF;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
